// File: rtl/gerenciador_de_posicionamento.sv
// Setup-phase fleet placement: validates each ship against bounds and
// overlap, then accumulates accepted ships into the 5x7 naval map.
module gerenciador_de_posicionamento #(
  parameter int TAM_NAVIO0 = 3,
  parameter int TAM_NAVIO1 = 2,
  parameter int TAM_NAVIO2 = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic       orientacao,
  input  logic       confirmar,
  output logic [6:0] mapa0,
  output logic [6:0] mapa1,
  output logic [6:0] mapa2,
  output logic [6:0] mapa3,
  output logic [6:0] mapa4,
  output logic [1:0] navio_atual,
  output logic       pronto,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B
);

  typedef enum logic [1:0] {
    OCIOSO,
    POSICIONA,
    VERIFICA,
    CONCLUIDO
  } estado_t;

  estado_t          state_q, state_d;
  logic             conf_ant_q, conf_ant_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       lin_q, lin_d;
  logic             ori_q, ori_d;
  logic [4:0][6:0]  mapa_q, mapa_d;
  logic [1:0]       navio_q, navio_d;
  logic             pronto_q, pronto_d;
  logic             led_r_q, led_r_d;
  logic             led_g_q, led_g_d;
  logic             led_b_q, led_b_d;

  logic             borda;
  logic [3:0]       tam;
  logic [3:0]       fim_h, fim_v;
  logic [4:0][6:0]  masc;
  logic             valido;

  assign borda = confirmar & ~conf_ant_q;

  always_comb begin
    tam = 4'd1;
    unique case (navio_q)
      2'd0:    tam = 4'(TAM_NAVIO0);
      2'd1:    tam = 4'(TAM_NAVIO1);
      2'd2:    tam = 4'(TAM_NAVIO2);
      default: tam = 4'd1;
    endcase
  end

  // 4-bit end coordinates so col/lin + length never wraps
  assign fim_h = {1'b0, col_q} + tam - 4'd1;
  assign fim_v = {1'b0, lin_q} + tam - 4'd1;

  always_comb begin
    masc = '0;
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 7; l++) begin
        if (!ori_q)
          masc[c][l] = (l == int'(lin_q)) &&
                       (c >= int'(col_q)) &&
                       (c < int'(col_q) + int'(tam));
        else
          masc[c][l] = (c == int'(col_q)) &&
                       (l >= int'(lin_q)) &&
                       (l < int'(lin_q) + int'(tam));
      end
    end
  end

  assign valido = (col_q <= 3'd4) && (lin_q <= 3'd6) &&
                  (ori_q ? (fim_v <= 4'd6) : (fim_h <= 4'd4)) &&
                  ((masc & mapa_q) == '0);

  always_comb begin
    state_d    = state_q;
    conf_ant_d = confirmar;
    col_d      = col_q;
    lin_d      = lin_q;
    ori_d      = ori_q;
    mapa_d     = mapa_q;
    navio_d    = navio_q;
    pronto_d   = pronto_q;
    led_r_d    = led_r_q;
    led_g_d    = led_g_q;
    led_b_d    = led_b_q;
    if (!enable) begin
      state_d  = OCIOSO;
      mapa_d   = '0;
      navio_d  = 2'd0;
      pronto_d = 1'b0;
      led_r_d  = 1'b0;
      led_g_d  = 1'b0;
      led_b_d  = 1'b0;
    end else begin
      unique case (state_q)
        OCIOSO: begin
          state_d = POSICIONA;
          led_b_d = 1'b1;
        end
        POSICIONA: begin
          if (borda) begin
            col_d   = coordColuna;
            lin_d   = coordLinha;
            ori_d   = orientacao;
            state_d = VERIFICA;
          end
        end
        VERIFICA: begin
          state_d = POSICIONA;
          if (valido) begin
            mapa_d  = mapa_q | masc;
            led_g_d = 1'b1;
            led_r_d = 1'b0;
            navio_d = navio_q + 2'd1;
            if (navio_q == 2'd2) begin
              state_d  = CONCLUIDO;
              pronto_d = 1'b1;
              led_b_d  = 1'b0;
            end
          end else begin
            led_r_d = 1'b1;
            led_g_d = 1'b0;
          end
        end
        CONCLUIDO: begin
          state_d = CONCLUIDO;
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= OCIOSO;
      conf_ant_q <= 1'b0;
      col_q      <= '0;
      lin_q      <= '0;
      ori_q      <= 1'b0;
      mapa_q     <= '0;
      navio_q    <= 2'd0;
      pronto_q   <= 1'b0;
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      conf_ant_q <= conf_ant_d;
      col_q      <= col_d;
      lin_q      <= lin_d;
      ori_q      <= ori_d;
      mapa_q     <= mapa_d;
      navio_q    <= navio_d;
      pronto_q   <= pronto_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
    end
  end

  assign mapa0       = mapa_q[0];
  assign mapa1       = mapa_q[1];
  assign mapa2       = mapa_q[2];
  assign mapa3       = mapa_q[3];
  assign mapa4       = mapa_q[4];
  assign navio_atual = navio_q;
  assign pronto      = pronto_q;
  assign LED_R       = led_r_q;
  assign LED_G       = led_g_q;
  assign LED_B       = led_b_q;

endmodule

// File: tb/tb_gerenciador_de_posicionamento.sv
// Bench for gerenciador_de_posicionamento: directed plan plus random
// fleets checked against a grid-level placement model.
module tb_gerenciador_de_posicionamento;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] coordColuna = '0;
  logic [2:0] coordLinha = '0;
  logic       orientacao = 1'b0;
  logic       confirmar = 1'b0;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
  logic [1:0] navio_atual;
  logic       pronto, LED_R, LED_G, LED_B;

  int n_tests = 0;
  int n_fail  = 0;

  gerenciador_de_posicionamento dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .coordColuna (coordColuna),
    .coordLinha  (coordLinha),
    .orientacao  (orientacao),
    .confirmar   (confirmar),
    .mapa0       (mapa0),
    .mapa1       (mapa1),
    .mapa2       (mapa2),
    .mapa3       (mapa3),
    .mapa4       (mapa4),
    .navio_atual (navio_atual),
    .pronto      (pronto),
    .LED_R       (LED_R),
    .LED_G       (LED_G),
    .LED_B       (LED_B)
  );

  always #5 clock = ~clock;

  // reference model: grid of occupied cells plus fleet progress
  bit m_grid [5][7];
  int m_ship;
  bit m_done, m_r, m_g, m_b;
  int lens [3] = '{3, 2, 1};

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] m_map();
    logic [34:0] v = '0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        v[c*7+r] = m_grid[c][r];
    return v;
  endfunction

  task automatic m_clear();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++)
        m_grid[c][r] = 1'b0;
    m_ship = 0;
    m_done = 0;
    m_r = 0; m_g = 0; m_b = 0;
  endtask

  task automatic m_apply(input int col, input int lin, input bit ori);
    bit ok = 1;
    int c, r;
    if (m_done) return;
    for (int k = 0; k < lens[m_ship]; k++) begin
      c = col + (ori ? 0 : k);
      r = lin + (ori ? k : 0);
      if (c > 4 || r > 6) ok = 0;
      else if (m_grid[c][r]) ok = 0;
    end
    if (ok) begin
      for (int k = 0; k < lens[m_ship]; k++)
        m_grid[col + (ori ? 0 : k)][lin + (ori ? k : 0)] = 1'b1;
      m_ship++;
      m_g = 1; m_r = 0;
      if (m_ship == 3) begin
        m_done = 1;
        m_b = 0;
      end
    end else begin
      m_r = 1; m_g = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".map"}, 64'({mapa4, mapa3, mapa2, mapa1, mapa0}),
        64'(m_map()));
    chk({tag, ".navio"}, 64'(navio_atual),
        64'(m_done ? 3 : m_ship));
    chk({tag, ".pronto"}, 64'(pronto), 64'(m_done));
    chk({tag, ".leds"}, 64'({LED_R, LED_G, LED_B}),
        64'({m_r, m_g, m_b}));
  endtask

  task automatic restart();
    enable = 1'b0;
    confirmar = 1'b0;
    step();
    m_clear();
    enable = 1'b1;
    step();
    m_b = 1;
  endtask

  // one confirm pulse; coordinates are scrambled after the latch edge
  task automatic place(input string tag, input int col, input int lin,
                       input bit ori);
    coordColuna = 3'(col);
    coordLinha  = 3'(lin);
    orientacao  = ori;
    confirmar   = 1'b1;
    step();
    coordColuna = 3'($urandom);
    coordLinha  = 3'($urandom);
    orientacao  = 1'($urandom);
    step();
    m_apply(col, lin, ori);
    check_all(tag);
    confirmar = 1'b0;
    step();
  endtask

  initial begin
    m_clear();
    enable = 1'b1;
    #2 reset = 1'b0;
    #1 check_all("reset");
    #9 reset = 1'b1;
    step();
    m_b = 1;
    check_all("idle_to_pos");

    place("s0", 0, 0, 0);
    place("s1_oob", 4, 6, 1);
    place("s1_ovl", 1, 0, 1);
    place("s1_ok", 1, 1, 1);
    chk("s1_mapa1", 64'(mapa1), 64'h07);
    place("s2", 4, 6, 0);
    chk("s2_mapa4", 64'(mapa4), 64'h40);
    place("done_ign", 3, 3, 0);

    // held button: one placement only
    restart();
    check_all("restart");
    coordColuna = 3'd2; coordLinha = 3'd2; orientacao = 1'b0;
    confirmar = 1'b1;
    step();
    m_apply(2, 2, 0);
    for (int i = 0; i < 19; i++) begin
      coordColuna = 3'($urandom);
      coordLinha  = 3'($urandom);
      orientacao  = 1'($urandom);
      step();
    end
    check_all("held");
    confirmar = 1'b0;
    step();

    // enable drop while verifying
    coordColuna = 3'd0; coordLinha = 3'd4; orientacao = 1'b0;
    confirmar = 1'b1;
    step();
    enable = 1'b0;
    step();
    m_clear();
    check_all("en_off_verif");
    confirmar = 1'b0;
    enable = 1'b1;
    step();
    m_b = 1;
    check_all("en_back");

    // async reset between edges
    place("pre_rst", 0, 0, 1);
    #2 reset = 1'b0;
    #1;
    m_clear();
    check_all("async_rst");
    #1 reset = 1'b1;
    step();
    m_b = 1;
    check_all("post_rst");

    // random fleets
    for (int round = 0; round < 20; round++) begin
      restart();
      for (int t = 0; t < 14 && !m_done; t++)
        place("rnd", int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 1'($urandom));
      if (m_done) place("rnd_ign", int'($urandom_range(0, 4)),
                        int'($urandom_range(0, 6)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
